// File: rtl/rf_alu_sequencer.sv
// rtl/rf_alu_sequencer.sv - four-state execute sequencer wrapped around an 8x8 register file
module rf_alu_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                    Clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [3+3*ADDR_W-1:0]   instr,
    output logic [ADDR_W-1:0]       RX,
    output logic [ADDR_W-1:0]       RY,
    input  logic [DATA_W-1:0]       busX,
    input  logic [DATA_W-1:0]       busY,
    output logic                    WEN,
    output logic [ADDR_W-1:0]       RW,
    output logic [DATA_W-1:0]       busW,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_W-1:0]       result,
    output logic                    carry,
    output logic                    zero
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;

    state_t state, next_state;

    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q, rs_q, rt_q;
    logic [DATA_W-1:0] opa, opb;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic [DATA_W:0]   alu_sum;
    logic              a_lt_b;
    logic              accept;

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = READ;
            READ:    next_state = EXEC;
            EXEC:    next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == IDLE);
        busy        = (state != IDLE);
        WEN         = (state == WB);
        done        = (state == WB);
    end

    // Write-back bus mirrors the registered result; RW tracks the latched rd.
    assign RW   = rd_q;
    assign busW = result;

    assign alu_sum = {1'b0, opa} + {1'b0, opb};
    assign a_lt_b  = (opa < opb);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: begin alu_res = alu_sum[DATA_W-1:0]; alu_c = alu_sum[DATA_W]; end
            OP_SUB: begin alu_res = opa - opb;           alu_c = a_lt_b;          end
            OP_AND: alu_res = opa & opb;
            OP_OR:  alu_res = opa | opb;
            OP_XOR: alu_res = opa ^ opb;
            OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, a_lt_b};
            OP_MOV: alu_res = opa;
            default: alu_res = DATA_W'({rs_q, rt_q});
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            rd_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            RX     <= '0;
            RY     <= '0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q <= instr[3+3*ADDR_W-1 -: 3];
                    rd_q <= instr[3*ADDR_W-1 -: ADDR_W];
                    rs_q <= instr[2*ADDR_W-1 -: ADDR_W];
                    rt_q <= instr[ADDR_W-1:0];
                    RX   <= instr[2*ADDR_W-1 -: ADDR_W];
                    RY   <= instr[ADDR_W-1:0];
                end
                READ: begin
                    opa <= busX;
                    opb <= busY;
                end
                EXEC: begin
                    result <= alu_res;
                    carry  <= alu_c;
                    zero   <= (alu_res == '0);
                end
                default: ;
            endcase
        end
    end

endmodule
